// File: rtl/calcdistance_seq.sv
// Sequential disparity-to-distance converter: distance = floor(K_NUM / disparity)
// via an MSB-first restoring divider. Optional clamp to MAX_DIST under DIST_SAT_EN.
module calcdistance_seq #(
   parameter int unsigned DISP_W   = 6,
   parameter int unsigned DIST_W   = 12,
   parameter int unsigned K_NUM    = 3300,
   parameter int unsigned MAX_DIST = 4095
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DISP_W-1:0] in_disp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIST_W-1:0] out_dist,
   output logic              out_div0,
   output logic              out_sat,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DIST_W + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIST_W - 1);
   localparam logic [DIST_W-1:0] K_VEC    = K_NUM[DIST_W-1:0];

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DISP_W-1:0] divisor_q, divisor_d;
   logic [DIST_W-1:0] dividend_q, dividend_d;
   logic [DISP_W:0]   rem_q, rem_d;
   logic [DIST_W-1:0] quot_q, quot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIST_W-1:0] dist_q, dist_d;
   logic              div0_q, div0_d;
   logic              sat_q, sat_d;

   logic [DISP_W:0]   rem_shift;
   logic [DISP_W:0]   rem_sub;
   logic              q_bit;
   logic [DIST_W-1:0] quot_next;

`ifdef DIST_SAT_EN
   localparam logic [DIST_W-1:0] MAX_VEC = MAX_DIST[DIST_W-1:0];
`else
   logic unused_max;
   assign unused_max = ^MAX_DIST;
`endif

   // rem stays below the divisor, so shifting the full register never loses a set bit
   assign rem_shift = (rem_q << 1) | (DISP_W + 1)'(dividend_q[DIST_W-1]);
   assign rem_sub   = rem_shift - {1'b0, divisor_q};
   assign q_bit     = (rem_shift >= {1'b0, divisor_q});
   assign quot_next = (quot_q << 1) | DIST_W'(q_bit);

   always_comb begin
      state_d    = state_q;
      divisor_d  = divisor_q;
      dividend_d = dividend_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      cnt_d      = cnt_q;
      dist_d     = dist_q;
      div0_d     = div0_q;
      sat_d      = sat_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_disp == '0) begin
                  state_d = S_DONE;
                  dist_d  = '0;
                  div0_d  = 1'b1;
                  sat_d   = 1'b0;
               end else begin
                  state_d    = S_DIV;
                  divisor_d  = in_disp;
                  dividend_d = K_VEC;
                  rem_d      = '0;
                  quot_d     = '0;
                  cnt_d      = '0;
               end
            end
         end
         S_DIV: begin
            rem_d      = q_bit ? rem_sub : rem_shift;
            quot_d     = quot_next;
            dividend_d = dividend_q << 1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               div0_d  = 1'b0;
               dist_d  = quot_next;
               sat_d   = 1'b0;
`ifdef DIST_SAT_EN
               if (quot_next > MAX_VEC) begin
                  dist_d = MAX_VEC;
                  sat_d  = 1'b1;
               end
`endif
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         divisor_q  <= '0;
         dividend_q <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         cnt_q      <= '0;
         dist_q     <= '0;
         div0_q     <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         divisor_q  <= divisor_d;
         dividend_q <= dividend_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         cnt_q      <= cnt_d;
         dist_q     <= dist_d;
         div0_q     <= div0_d;
         sat_q      <= sat_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_dist  = dist_q;
   assign out_div0  = div0_q;
`ifdef DIST_SAT_EN
   assign out_sat   = sat_q;
`else
   assign out_sat   = 1'b0;
`endif

endmodule
